// File: rtl/sle_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sle_load_arbiter
// Description : Round-robin sequencer sharing the EN/SLn/SD/D load port of a
//               register-cell bank among NREQ requesters.
//               Optional macro SLE_LOAD_ARBITER_PRIO0_EN gives requester 0
//               fixed priority over the round-robin order.
// Revision    : 1.0 - initial release
// ============================================================================
module sle_load_arbiter #(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                  CLK,
    input  logic                  ALn,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       op,
    input  logic [NREQ-1:0]       sd_val,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic                  EN,
    output logic                  SLn,
    output logic                  SD,
    output logic [WIDTH-1:0]      D
);

    localparam int C_PW = $clog2(NREQ);

    localparam logic [2:0] C_IDLE   = 3'd0;
    localparam logic [2:0] C_GRANT  = 3'd1;
    localparam logic [2:0] C_DRIVE  = 3'd2;
    localparam logic [2:0] C_SETTLE = 3'd3;
    localparam logic [2:0] C_DONE   = 3'd4;

    localparam logic [C_PW-1:0] C_LAST      = C_PW'(NREQ - 1);
    localparam logic [NREQ-1:0] C_ONE       = {{(NREQ-1){1'b0}}, 1'b1};
    localparam logic [3:0]      C_HOLD_LAST = (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [C_PW-1:0]  r_ptr;
    logic [C_PW-1:0]  r_win;
    logic             r_op;
    logic             r_sdv;
    logic [WIDTH-1:0] r_data;
    logic [3:0]       r_cnt;
    logic [NREQ-1:0]  r_gnt;
    logic [NREQ-1:0]  r_done;
    logic             r_busy;
    logic             r_en;
    logic             r_sln;
    logic             r_sd;
    logic [WIDTH-1:0] r_d;

    logic [NREQ-1:0]  w_win_oh;
    logic [NREQ-1:0]  w_cand;
    logic [C_PW-1:0]  w_ptr_after;
    logic [C_PW-1:0]  w_base;
    logic [C_PW-1:0]  w_pick;
    logic [C_PW:0]    w_idx;
    logic             w_found;
    logic             w_pick_op;
    logic             w_pick_sd;
    logic [WIDTH-1:0] w_pick_data;

    assign w_win_oh = C_ONE << r_win;

    // Arbitration; in DONE the finishing requester is excluded and the search
    // starts from the pointer value that DONE is about to commit.
    always_comb begin : p_arb
        w_ptr_after = (r_win == C_LAST) ? '0 : r_win + C_PW'(1);
`ifdef SLE_LOAD_ARBITER_PRIO0_EN
        if (r_win == '0) begin
            w_ptr_after = r_ptr;
        end
`endif
        if (r_state == C_DONE) begin
            w_base = w_ptr_after;
            w_cand = req & ~w_win_oh;
        end else begin
            w_base = r_ptr;
            w_cand = req;
        end
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
`ifdef SLE_LOAD_ARBITER_PRIO0_EN
        if (w_cand[0]) begin
            w_found = 1'b1;
        end
`endif
        for (int i = 0; i < NREQ; i++) begin
            w_idx = {1'b0, w_base} + (C_PW+1)'(i);
            if (w_idx >= (C_PW+1)'(NREQ)) begin
                w_idx = w_idx - (C_PW+1)'(NREQ);
            end
            if (!w_found && w_cand[w_idx[C_PW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[C_PW-1:0];
            end
        end
    end

    always_comb begin : p_pick
        w_pick_op   = 1'b0;
        w_pick_sd   = 1'b0;
        w_pick_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (C_PW'(i) == w_pick) begin
                w_pick_op   = op[i];
                w_pick_sd   = sd_val[i];
                w_pick_data = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin : p_next
        w_next = r_state;
        case (r_state)
            C_IDLE:   if (w_found) w_next = C_GRANT;
            C_GRANT:  w_next = C_DRIVE;
            C_DRIVE:  w_next = (HOLD_CYCLES > 0) ? C_SETTLE : C_DONE;
            C_SETTLE: if (r_cnt == '0) w_next = C_DONE;
            C_DONE:   w_next = w_found ? C_GRANT : C_IDLE;
            default:  w_next = C_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge ALn) begin : p_state
        if (!ALn) begin
            r_state <= C_IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_op    <= 1'b0;
            r_sdv   <= 1'b0;
            r_data  <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_en    <= 1'b0;
            r_sln   <= 1'b1;
            r_sd    <= 1'b0;
            r_d     <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != C_IDLE);
            // Strobes are decoded from the next state so the pins are clean flops.
            r_en    <= (w_next == C_DRIVE);
            r_sln   <= !((w_next == C_DRIVE) && r_op);
            r_done  <= (w_next == C_DONE) ? w_win_oh : '0;

            if (w_next == C_DRIVE) begin
                if (r_op) begin
                    r_sd <= r_sdv;
                end else begin
                    r_d  <= r_data;
                end
            end

            if (w_next == C_GRANT) begin
                r_win  <= w_pick;
                r_gnt  <= C_ONE << w_pick;
                r_op   <= w_pick_op;
                r_sdv  <= w_pick_sd;
                r_data <= w_pick_data;
            end else if (r_state == C_DONE) begin
                r_gnt  <= '0;
            end

            if (r_state == C_DONE) begin
                r_ptr <= w_ptr_after;
            end

            if ((r_state == C_DRIVE) && (w_next == C_SETTLE)) begin
                r_cnt <= C_HOLD_LAST;
            end else if (r_state == C_SETTLE) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    assign gnt  = r_gnt;
    assign done = r_done;
    assign busy = r_busy;
    assign EN   = r_en;
    assign SLn  = r_sln;
    assign SD   = r_sd;
    assign D    = r_d;

endmodule
`default_nettype wire
